// File: rtl/ready_pipe_if.sv
// dti link: data/valid flow producer -> consumer, ready flows back.
// A transfer happens on a rising edge where valid & ready are both high.
//   data  : W-bit payload, driven by the producer
//   valid : payload present, driven by the producer
//   ready : consumer can take the payload, driven by the consumer
// The master/producer and slave/consumer modports describe the same two views.
interface dti #(
    parameter int unsigned W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
    modport master   (output data, output valid, input ready);
    modport slave    (input data, input valid, output ready);
endinterface

// File: rtl/ready_pipe.sv
// ready_pipe: LENGTH chained skid stages that register the backpressure path.
// Each stage's upstream ready comes only from its own skid flag, so din.ready
// never depends combinationally on dout.ready. Data and valid flow through a
// stage combinationally while its skid is empty, so forward latency is zero
// when nothing is stalled. LENGTH = 0 degenerates to plain wires.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every skid
//   din  : upstream dti link (this block is the consumer)
//   dout : downstream dti link (this block is the producer)
module ready_pipe #(
    parameter int unsigned LENGTH = 2,
    parameter int unsigned DIN    = 16
) (
    input  logic clk,
    input  logic rst,
    dti.consumer din,
    dti.producer dout
);

    generate
        if (LENGTH == 0) begin : g_wire
            assign dout.data  = din.data;
            assign dout.valid = din.valid;
            assign din.ready  = dout.ready;
        end else begin : g_chain
            for (genvar i = 0; i < int'(LENGTH); i++) begin : g_stage
                logic [DIN-1:0] in_data;
                logic           in_valid;
                logic           in_ready;
                logic [DIN-1:0] out_data;
                logic           out_valid;
                logic           out_ready;
                logic           skid_valid;
                logic [DIN-1:0] skid_data;

                // Stage 0 faces din; every other stage faces the one before it.
                if (i == 0) begin : g_head
                    assign in_data  = din.data;
                    assign in_valid = din.valid;
                end else begin : g_link_in
                    assign in_data  = g_stage[i-1].out_data;
                    assign in_valid = g_stage[i-1].out_valid;
                end

                // The last stage faces dout; others see the next stage's registered ready.
                if (i == int'(LENGTH) - 1) begin : g_tail
                    assign out_ready = dout.ready;
                end else begin : g_link_out
                    assign out_ready = g_stage[i+1].in_ready;
                end

                // Skid: catch the item that was in flight when downstream stalled,
                // release it on the first ready edge. A full skid cannot refill on
                // the edge it drains because in_ready is low that cycle.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        skid_valid <= 1'b0;
                        skid_data  <= '0;
                    end else if (!skid_valid && in_valid && !out_ready) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end else if (skid_valid && out_ready) begin
                        skid_valid <= 1'b0;
                    end
                end

                assign in_ready  = !skid_valid;
                assign out_valid = skid_valid | in_valid;
                assign out_data  = skid_valid ? skid_data : in_data;
            end

            assign din.ready  = g_stage[0].in_ready;
            assign dout.valid = g_stage[LENGTH-1].out_valid;
            assign dout.data  = g_stage[LENGTH-1].out_data;
        end
    endgenerate

endmodule

// File: tb/tb_ready_pipe.sv
// Bench for ready_pipe: LENGTH=2 instance with a queue scoreboard plus a
// LENGTH=0 instance checked as pure wiring.
module tb_ready_pipe;

    localparam int unsigned DW       = 16;
    localparam int unsigned N_RAND   = 10000;
    localparam int unsigned MAX_CYC  = 80000;

    logic clk;
    logic rst;

    dti #(.W(DW)) a ();
    dti #(.W(DW)) b ();
    dti #(.W(DW)) wa ();
    dti #(.W(DW)) wb ();

    ready_pipe #(.LENGTH(2), .DIN(DW)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .din  (a),
        .dout (b)
    );

    ready_pipe #(.LENGTH(0), .DIN(DW)) u_wire (
        .clk  (clk),
        .rst  (rst),
        .din  (wa),
        .dout (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: inputs pushed on din transfers, popped on dout transfers.
    logic [DW-1:0] sb_q[$];
    logic          mon_en    = 1'b0;
    logic          in_fire   = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int unsigned   n_out     = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            in_fire = a.valid && a.ready;
            if (in_fire) sb_q.push_back(a.data);
            if (b.valid && b.ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'(b.data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", 32'(b.data), 32'(sb_q.pop_front()));
                    n_out++;
                end
            end
            if (hold_prev) begin
                check("hold_valid", 32'(b.valid), 32'd1);
                check("hold_data", 32'(b.data), 32'(hold_data));
            end
            hold_prev = b.valid && !b.ready;
            hold_data = b.data;
        end else begin
            in_fire   = 1'b0;
            hold_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned sent;
        int unsigned cyc;

        rst      = 1'b1;
        a.valid  = 1'b0;
        a.data   = '0;
        b.ready  = 1'b1;
        wa.valid = 1'b0;
        wa.data  = '0;
        wb.ready = 1'b0;
        repeat (2) step();
        check("rst_din_ready", 32'(a.ready), 32'd1);
        check("rst_dout_valid", 32'(b.valid), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_din_ready", 32'(a.ready), 32'd1);
        mon_en = 1'b1;

        // Back-to-back stream with dout always ready: same-cycle pass-through.
        for (int i = 1; i <= 16; i++) begin
            a.valid = 1'b1;
            a.data  = DW'(i);
            #1;
            check("s1_din_ready", 32'(a.ready), 32'd1);
            check("s1_dout_valid", 32'(b.valid), 32'd1);
            check("s1_dout_data", 32'(b.data), 32'(i));
            step();
        end
        a.valid = 1'b0;
        step();
        check("s1_count", n_out, 32'd16);

        // Stall for 4 cycles while 0x0100 is presented.
        a.valid = 1'b1;
        a.data  = 16'h0100;
        b.ready = 1'b0;
        #1;
        check("s2_c0_din_ready", 32'(a.ready), 32'd1);
        check("s2_c0_dout_data", 32'(b.data), 32'h0100);
        step();
        a.data = 16'h0101;
        #1;
        check("s2_c1_din_ready", 32'(a.ready), 32'd1);
        check("s2_c1_dout_data", 32'(b.data), 32'h0100);
        step();
        a.data = 16'h0102;
        #1;
        check("s2_c2_din_ready", 32'(a.ready), 32'd0);
        step();
        check("s2_c3_din_ready", 32'(a.ready), 32'd0);
        step();
        b.ready = 1'b1;
        #1;
        check("s2_rel0_dout_data", 32'(b.data), 32'h0100);
        check("s2_rel0_din_ready", 32'(a.ready), 32'd0);
        step();
        check("s2_rel1_dout_data", 32'(b.data), 32'h0101);
        check("s2_rel1_din_ready", 32'(a.ready), 32'd0);
        step();
        check("s2_rel2_dout_data", 32'(b.data), 32'h0102);
        check("s2_rel2_din_ready", 32'(a.ready), 32'd1);
        step();
        a.data = 16'h0103;
        step();
        a.valid = 1'b0;
        repeat (3) step();
        check("s2_drained", sb_q.size(), 32'd0);

        // Random valid/ready traffic with incrementing data.
        sent = 0;
        cyc  = 0;
        a.valid = 1'b0;
        while ((sent < N_RAND || sb_q.size() != 0) && cyc < MAX_CYC) begin
            if (in_fire) begin
                sent++;
                a.valid = 1'b0;
            end
            if (!a.valid && sent < N_RAND && ($urandom % 2) == 0) begin
                a.valid = 1'b1;
                a.data  = DW'(sent);
            end
            b.ready = ($urandom % 10) < 3;
            step();
            cyc++;
        end
        check("s3_timeout", 32'(cyc < MAX_CYC), 32'd1);
        check("s3_sent", sent, N_RAND);
        a.valid = 1'b0;
        b.ready = 1'b1;
        repeat (3) step();

        // din.ready must not follow mid-cycle dout.ready changes.
        a.valid = 1'b0;
        b.ready = 1'b0;
        #1;
        check("s4_ready_a", 32'(a.ready), 32'd1);
        b.ready = 1'b1;
        #1;
        check("s4_ready_b", 32'(a.ready), 32'd1);
        b.ready = 1'b0;
        #1;
        check("s4_ready_c", 32'(a.ready), 32'd1);
        b.ready = 1'b1;
        step();

        // Fill both skids, then reset asynchronously mid-cycle.
        a.valid = 1'b1;
        a.data  = 16'h00A0;
        b.ready = 1'b0;
        step();
        a.data = 16'h00A1;
        step();
        check("s5_full_din_ready", 32'(a.ready), 32'd0);
        mon_en = 1'b0;
        a.data = 16'hBEEF;
        #2;
        rst = 1'b1;
        #1;
        check("s5_rst_din_ready", 32'(a.ready), 32'd1);
        check("s5_rst_dout_valid", 32'(b.valid), 32'd1);
        check("s5_rst_dout_data", 32'(b.data), 32'hBEEF);
        a.valid = 1'b0;
        #1;
        check("s5_rst_dout_valid0", 32'(b.valid), 32'd0);
        step();
        rst = 1'b0;
        sb_q.delete();
        a.valid = 1'b0;
        b.ready = 1'b1;
        step();
        mon_en = 1'b1;
        n_out  = 0;
        for (int i = 0; i < 6; i++) begin
            a.valid = 1'b1;
            a.data  = DW'(16'h00C0 + i);
            b.ready = (i % 2) == 0;
            step();
            while (!in_fire) step();
        end
        a.valid = 1'b0;
        b.ready = 1'b1;
        repeat (4) step();
        check("s5_post_rst_count", n_out, 32'd6);
        check("s5_post_rst_empty", sb_q.size(), 32'd0);

        // LENGTH=0: everything is a wire.
        for (int i = 0; i < 8; i++) begin
            wa.valid = (i % 3) != 2;
            wa.data  = DW'(16'h5A00 + i * 7);
            wb.ready = (i % 2) == 1;
            #1;
            check("w_data", 32'(wb.data), 32'(16'h5A00 + i * 7));
            check("w_valid", 32'(wb.valid), 32'((i % 3) != 2));
            check("w_ready", 32'(wa.ready), 32'((i % 2) == 1));
            wb.ready = !wb.ready;
            #1;
            check("w_ready_toggle", 32'(wa.ready), 32'((i % 2) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
